// File: rtl/pipe_pkg.sv
// Shared definitions for the MEM stage: access-size encodings, the default
// I/O select bit, and small helpers for lane enables, store replication,
// alignment checks and load formatting.
package pipe_pkg;

    typedef enum logic [1:0] {
        SZ_BYTE  = 2'b00,
        SZ_HALF  = 2'b01,
        SZ_WORD  = 2'b10,
        SZ_WORDX = 2'b11
    } msize_e;

    localparam int IO_BIT_DEF = 7;

    // Encoding 11 behaves exactly like a word access.
    function automatic logic is_word(input msize_e size);
        return (size == SZ_WORD) || (size == SZ_WORDX);
    endfunction

    // Byte-lane write enables for a store of the given size at the given lane.
    function automatic logic [3:0] byte_enables(input msize_e size, input logic [1:0] lane);
        logic [3:0] be;
        case (size)
            SZ_BYTE: be = 4'b0001 << lane;
            SZ_HALF: be = lane[1] ? 4'b1100 : 4'b0011;
            default: be = 4'b1111;
        endcase
        return be;
    endfunction

    // Right-aligned store data replicated across every lane it could land in.
    function automatic logic [31:0] store_lanes(input msize_e size, input logic [31:0] data);
        logic [31:0] w;
        case (size)
            SZ_BYTE: w = {4{data[7:0]}};
            SZ_HALF: w = {2{data[15:0]}};
            default: w = data;
        endcase
        return w;
    endfunction

    // True when the address offset is not a multiple of the access size.
    function automatic logic misaligned(input msize_e size, input logic [1:0] lane);
        logic m;
        case (size)
            SZ_BYTE: m = 1'b0;
            SZ_HALF: m = lane[0];
            default: m = (lane != 2'b00);
        endcase
        return m;
    endfunction

    // Extract the addressed byte/half from a RAM word and extend it.
    function automatic logic [31:0] load_format(input logic [31:0] word, input msize_e size,
                                                input logic [1:0] lane, input logic uns);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        b = word[8*lane +: 8];
        h = lane[1] ? word[31:16] : word[15:0];
        case (size)
            SZ_BYTE: r = uns ? {24'b0, b} : {{24{b[7]}}, b};
            SZ_HALF: r = uns ? {16'b0, h} : {{16{h[15]}}, h};
            default: r = word;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/pipemem_ram.sv
// DEPTH x 32 single-port data RAM with per-byte write enables and a
// registered read port. Written in the plain style block-RAM inference
// expects: no reset on the array or the read register.
module pipemem_ram #(
    parameter  int DEPTH = 256,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic          clock,
    input  logic [3:0]    be,
    input  logic [AW-1:0] addr,
    input  logic [31:0]   wdata,
    output logic [31:0]   rdata
);

    logic [31:0] mem [DEPTH];

    // Byte-enabled write and read-first synchronous read on the same address.
    always_ff @(posedge clock) begin
        for (int i = 0; i < 4; i++) begin
            if (be[i]) begin
                mem[addr][8*i +: 8] <= wdata[8*i +: 8];
            end
        end
        rdata <= mem[addr];
    end

endmodule

// File: rtl/pipemem_io.sv
// MEM stage of the pipelined CPU: decodes the EX/MEM address into data RAM
// or memory-mapped I/O, performs byte/half/word stores, synchronises the
// external input ports, and presents a registered MEM/WB result one cycle
// after each access.
module pipemem_io
    import pipe_pkg::*;
#(
    parameter int          DEPTH   = 256,
    parameter int          N_IN    = 2,
    parameter int          N_OUT   = 3,
    parameter int          IO_BIT  = IO_BIT_DEF,
    parameter logic [31:0] OUT_RST = 32'h0
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  mvalid,
    input  logic                  mwmem,
    input  logic [1:0]            msize,
    input  logic                  munsigned,
    input  logic [31:0]           malu,
    input  logic [31:0]           mb,
    input  logic [32*N_IN-1:0]    in_ports,
    output logic [32*N_OUT-1:0]   out_ports,
    output logic [31:0]           mmo,
    output logic                  mmo_valid,
    output logic                  merr
);

    localparam int AW = $clog2(DEPTH);
    localparam int IW = IO_BIT - 2;

    msize_e        size_in;
    logic          is_io;
    logic [AW-1:0] word_idx;
    logic [IW-1:0] io_idx;
    logic          acc_err;
    logic [3:0]    ram_be;
    logic [31:0]   ram_wdata;
    logic [31:0]   ram_rdata;
    logic [31:0]   io_rdata;
    logic [N_OUT-1:0] out_we;
    logic          unused_addr;

    logic [31:0] sync1   [N_IN];
    logic [31:0] sync2   [N_IN];
    logic [31:0] out_reg [N_OUT];

    logic          r_valid;
    logic          r_err;
    logic          r_load;
    logic          r_io;
    logic [1:0]    r_lane;
    msize_e        r_size;
    logic          r_uns;
    logic [31:0]   r_io_data;
    logic [31:0]   mmo_hold;
    logic [31:0]   fresh;

    assign size_in     = msize_e'(msize);
    assign unused_addr = ^malu;

    // Address decode, legality check and RAM write lane generation.
    always_comb begin
        is_io     = malu[IO_BIT];
        word_idx  = malu[AW+1:2];
        io_idx    = malu[IO_BIT-1:2];
        acc_err   = misaligned(size_in, malu[1:0]) || (is_io && !is_word(size_in));
        ram_be    = '0;
        if (mvalid && mwmem && !acc_err && !is_io) begin
            ram_be = byte_enables(size_in, malu[1:0]);
        end
        ram_wdata = store_lanes(size_in, mb);
    end

    // I/O read mux and output-port write enables; unmapped indices read 0.
    always_comb begin
        io_rdata = '0;
        out_we   = '0;
        for (int k = 0; k < N_IN; k++) begin
            if (int'(io_idx) == k) begin
                io_rdata = sync2[k];
            end
        end
        for (int k = 0; k < N_OUT; k++) begin
            if (int'(io_idx) == N_IN + k) begin
                io_rdata  = out_reg[k];
                out_we[k] = mvalid && mwmem && is_io && !acc_err;
            end
        end
    end

    pipemem_ram #(
        .DEPTH (DEPTH)
    ) u_ram (
        .clock (clock),
        .be    (ram_be),
        .addr  (word_idx),
        .wdata (ram_wdata),
        .rdata (ram_rdata)
    );

    // Two-flop synchroniser for every asynchronous input port.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int k = 0; k < N_IN; k++) begin
                sync1[k] <= '0;
                sync2[k] <= '0;
            end
        end else begin
            for (int k = 0; k < N_IN; k++) begin
                sync1[k] <= in_ports[32*k +: 32];
                sync2[k] <= sync1[k];
            end
        end
    end

    // Output port registers, written as full words by legal I/O stores.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int k = 0; k < N_OUT; k++) begin
                out_reg[k] <= OUT_RST;
            end
        end else begin
            for (int k = 0; k < N_OUT; k++) begin
                if (out_we[k]) begin
                    out_reg[k] <= mb;
                end
            end
        end
    end

    // Flatten the output registers onto the port bus.
    always_comb begin
        out_ports = '0;
        for (int k = 0; k < N_OUT; k++) begin
            out_ports[32*k +: 32] = out_reg[k];
        end
    end

    // MEM/WB register: remembers what the access was so the RAM's registered
    // read data can be formatted next cycle; mmo_hold keeps mmo stable on bubbles.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_valid   <= 1'b0;
            r_err     <= 1'b0;
            r_load    <= 1'b0;
            r_io      <= 1'b0;
            r_lane    <= 2'b00;
            r_size    <= SZ_WORD;
            r_uns     <= 1'b0;
            r_io_data <= '0;
            mmo_hold  <= '0;
        end else begin
            r_valid   <= mvalid;
            r_err     <= mvalid && acc_err;
            r_load    <= mvalid && !mwmem && !acc_err;
            r_io      <= is_io;
            r_lane    <= malu[1:0];
            r_size    <= size_in;
            r_uns     <= munsigned;
            r_io_data <= io_rdata;
            mmo_hold  <= mmo;
        end
    end

    // Load result formatting: zero for stores and faulting accesses.
    always_comb begin
        fresh = '0;
        if (r_load) begin
            fresh = r_io ? r_io_data : load_format(ram_rdata, r_size, r_lane, r_uns);
        end
        mmo = r_valid ? fresh : mmo_hold;
    end

    assign mmo_valid = r_valid;
    assign merr      = r_valid && r_err;

endmodule

// File: tb/tb_pipemem_io.sv
// Scoreboard bench for pipemem_io: each issued access pushes its expected
// MEM/WB response; a monitor pops and compares whenever mmo_valid is seen.
module tb_pipemem_io;

    localparam logic [31:0] OUT_RST_TB = 32'h0000_00C3;
    localparam logic [1:0]  SZ_B = 2'b00;
    localparam logic [1:0]  SZ_H = 2'b01;
    localparam logic [1:0]  SZ_W = 2'b10;

    logic        clock;
    logic        reset;
    logic        mvalid;
    logic        mwmem;
    logic [1:0]  msize;
    logic        munsigned;
    logic [31:0] malu;
    logic [31:0] mb;
    logic [63:0] in_ports;
    logic [95:0] out_ports;
    logic [31:0] mmo;
    logic        mmo_valid;
    logic        merr;

    int compared   = 0;
    int mismatched = 0;

    string       name_q [$];
    logic [31:0] mmo_q  [$];
    logic        err_q  [$];

    pipemem_io #(
        .DEPTH   (256),
        .N_IN    (2),
        .N_OUT   (3),
        .IO_BIT  (7),
        .OUT_RST (OUT_RST_TB)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .mvalid    (mvalid),
        .mwmem     (mwmem),
        .msize     (msize),
        .munsigned (munsigned),
        .malu      (malu),
        .mb        (mb),
        .in_ports  (in_ports),
        .out_ports (out_ports),
        .mmo       (mmo),
        .mmo_valid (mmo_valid),
        .merr      (merr)
    );

    // Free-running clock.
    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Hard stop in case the run ever stalls.
    initial begin
        #50000;
        $display("[TB] FAIL watchdog: got timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
        end
    endtask

    // Drive one access just after a rising edge and record its expected response.
    task automatic applyStimulus(input string name, input logic we, input logic [1:0] size,
                                 input logic uns, input logic [31:0] addr, input logic [31:0] data,
                                 input logic [31:0] exp_mmo, input logic exp_err);
        @(posedge clock);
        #1;
        mvalid    = 1'b1;
        mwmem     = we;
        msize     = size;
        munsigned = uns;
        malu      = addr;
        mb        = data;
        name_q.push_back(name);
        mmo_q.push_back(exp_mmo);
        err_q.push_back(exp_err);
    endtask

    task automatic applyIdle();
        @(posedge clock);
        #1;
        mvalid = 1'b0;
        mwmem  = 1'b0;
    endtask

    // Monitor: compare every presented response against the scoreboard.
    always @(negedge clock) begin
        if (!reset && mmo_valid) begin
            if (name_q.size() == 0) begin
                checkOutput("unexpected_valid", {31'b0, mmo_valid}, 32'h0);
            end else begin
                string       n;
                logic [31:0] em;
                logic        ee;
                n  = name_q.pop_front();
                em = mmo_q.pop_front();
                ee = err_q.pop_front();
                checkOutput({n, "_mmo"}, mmo, em);
                checkOutput({n, "_merr"}, {31'b0, merr}, {31'b0, ee});
            end
        end
    end

    initial begin
        reset     = 1'b1;
        mvalid    = 1'b0;
        mwmem     = 1'b0;
        msize     = SZ_W;
        munsigned = 1'b0;
        malu      = '0;
        mb        = '0;
        in_ports  = '0;
        #3;
        checkOutput("rst_mmo", mmo, 32'h0);
        checkOutput("rst_mmo_valid", {31'b0, mmo_valid}, 32'h0);
        checkOutput("rst_merr", {31'b0, merr}, 32'h0);
        checkOutput("rst_out0", out_ports[31:0], OUT_RST_TB);
        checkOutput("rst_out2", out_ports[95:64], OUT_RST_TB);
        repeat (2) @(negedge clock);
        reset = 1'b0;

        applyStimulus("st_w10",    1'b1, SZ_W, 1'b0, 32'h10, 32'hDEADBEEF, 32'h0, 1'b0);
        applyStimulus("ld_w10",    1'b0, SZ_W, 1'b0, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0);
        applyStimulus("st_w20",    1'b1, SZ_W, 1'b0, 32'h20, 32'h11223344, 32'h0, 1'b0);
        applyStimulus("st_b21",    1'b1, SZ_B, 1'b0, 32'h21, 32'h000000AA, 32'h0, 1'b0);
        applyStimulus("ld_w20",    1'b0, SZ_W, 1'b0, 32'h20, 32'h0, 32'h1122AA44, 1'b0);
        applyStimulus("ld_b21s",   1'b0, SZ_B, 1'b0, 32'h21, 32'h0, 32'hFFFFFFAA, 1'b0);
        applyStimulus("ld_b21u",   1'b0, SZ_B, 1'b1, 32'h21, 32'h0, 32'h000000AA, 1'b0);
        applyStimulus("ld_h22s",   1'b0, SZ_H, 1'b0, 32'h22, 32'h0, 32'h00001122, 1'b0);
        applyStimulus("ld_b20s",   1'b0, SZ_B, 1'b0, 32'h20, 32'h0, 32'h00000044, 1'b0);
        applyStimulus("st_w13bad", 1'b1, SZ_W, 1'b0, 32'h13, 32'hFFFFFFFF, 32'h0, 1'b1);
        applyStimulus("ld_w10b",   1'b0, SZ_W, 1'b0, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0);
        applyStimulus("ld_h11bad", 1'b0, SZ_H, 1'b0, 32'h11, 32'h0, 32'h0, 1'b1);

        applyStimulus("st_out0",   1'b1, SZ_W, 1'b0, 32'h88, 32'h00000005, 32'h0, 1'b0);
        applyStimulus("ld_out0",   1'b0, SZ_W, 1'b0, 32'h88, 32'h0, 32'h00000005, 1'b0);
        checkOutput("out0_after_store", out_ports[31:0], 32'h5);
        applyStimulus("st_out0b",  1'b1, SZ_B, 1'b0, 32'h88, 32'h000000FF, 32'h0, 1'b1);
        applyIdle();
        checkOutput("out0_after_bad", out_ports[31:0], 32'h5);

        in_ports[63:32] = 32'h00001234;
        applyIdle();
        applyStimulus("ld_in1",    1'b0, SZ_W, 1'b0, 32'h84, 32'h0, 32'h00001234, 1'b0);
        applyStimulus("ld_unmap",  1'b0, SZ_W, 1'b0, 32'h9C, 32'h0, 32'h0, 1'b0);
        applyStimulus("st_out2",   1'b1, SZ_W, 1'b0, 32'h90, 32'hCAFEF00D, 32'h0, 1'b0);
        applyStimulus("ld_out2",   1'b0, SZ_W, 1'b0, 32'h90, 32'h0, 32'hCAFEF00D, 1'b0);
        checkOutput("out2_after_store", out_ports[95:64], 32'hCAFEF00D);
        checkOutput("out1_untouched", out_ports[63:32], OUT_RST_TB);

        applyStimulus("st_w000",   1'b1, SZ_W, 1'b0, 32'h000, 32'h00000077, 32'h0, 1'b0);
        applyStimulus("ld_w400",   1'b0, SZ_W, 1'b0, 32'h400, 32'h0, 32'h00000077, 1'b0);
        applyIdle();
        applyIdle();
        checkOutput("bubble_valid", {31'b0, mmo_valid}, 32'h0);
        checkOutput("bubble_hold", mmo, 32'h00000077);

        // In-flight load cut short by an asynchronous reset.
        applyStimulus("ld_pre_rst", 1'b0, SZ_W, 1'b0, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0);
        @(posedge clock);
        #1;
        malu = 32'h20;
        @(posedge clock);
        #1;
        checkOutput("inflight_valid", {31'b0, mmo_valid}, 32'h1);
        checkOutput("inflight_mmo", mmo, 32'h1122AA44);
        mvalid = 1'b0;
        #1;
        reset = 1'b1;
        #1;
        checkOutput("midrst_mmo_valid", {31'b0, mmo_valid}, 32'h0);
        checkOutput("midrst_mmo", mmo, 32'h0);
        checkOutput("midrst_out0", out_ports[31:0], OUT_RST_TB);
        checkOutput("midrst_out2", out_ports[95:64], OUT_RST_TB);
        repeat (2) @(negedge clock);
        reset = 1'b0;

        applyStimulus("ld_post_10", 1'b0, SZ_W, 1'b0, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0);
        applyStimulus("ld_post_20", 1'b0, SZ_W, 1'b0, 32'h20, 32'h0, 32'h1122AA44, 1'b0);
        applyIdle();

        for (int i = 0; i < 20 && name_q.size() != 0; i++) begin
            @(negedge clock);
        end
        checkOutput("queue_drained", name_q.size(), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
